// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the memory port arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_MEM_LAT    = 4;
  localparam int DEF_STARVE_MAX = 3;

  // Width of the latency counter: it only has to hold MEM_LAT-1, but never
  // collapse to zero bits when MEM_LAT is 1.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory latency of one access.
module mem_lat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement stops at zero so the flag stays stable.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle single-ported memory between instruction fetch and
// the load/store path. Each access is a fixed IDLE -> BUSY(MEM_LAT) -> DONE
// transaction; data wins ties unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = cnt_width(MEM_LAT);
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic cnt_load, cnt_dec, cnt_zero;
  logic pick_d;

  mem_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(LAT_LOAD),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // Data wins unless fetch is also waiting and has hit the starvation limit.
  assign pick_d = d_req & ~(if_req & (starve_q == STV_SAT));

  // Next-state, grant latching, read capture and starvation bookkeeping.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    starve_d   = starve_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          cnt_load = 1'b1;
          state_d  = BUSY;
          if (pick_d) begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wr_d    = d_wr;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STV_SAT) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            owner_d  = OWN_IF;
            addr_d   = if_addr;
            wdata_d  = '0;
            wr_d     = 1'b0;
            starve_d = '0;
          end
        end
      end
      BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = DONE;
          if (!wr_q) begin
            if (owner_q == OWN_D) d_rdata_d  = mem_data_out;
            else                  if_rdata_d = mem_data_out;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      starve_q   <= starve_d;
    end
  end

  // Memory pins: write strobe is qualified by the busy phase so it can never
  // appear without enable.
  assign mem_enable  = (state_q == BUSY);
  assign mem_wr      = (state_q == BUSY) & wr_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

  assign if_done  = (state_q == DONE) & (owner_q == OWN_IF);
  assign d_done   = (state_q == DONE) & (owner_q == OWN_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Stalls hold the requester until its completion pulse; forced low in reset.
  assign if_stall = if_req & ~if_done & ~rst;
  assign d_stall  = d_req & ~d_done & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory1c model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(4), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preset contents are addr ^ 0x5A00, except 0x0010 = 0xA5A5.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i == 16) ? 16'hA5A5 : (16'(i) ^ 16'h5A00);
    end else if (mem_enable && mem_wr) begin
      mem[mem_addr[9:0]] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_addr[9:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until either done pulse is seen; n = cycles advanced (20 = timeout).
  task automatic wait_done(output int n);
    n = 0;
    while (!(if_done || d_done) && n < 20) begin
      tick();
      n++;
    end
  endtask

  int n;
  int own;
  logic [15:0] exp_addr;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;

    // 1. Reset with random inputs.
    if_req  = 1'($urandom); if_addr = 16'($urandom);
    d_req   = 1'($urandom); d_wr    = 1'($urandom);
    d_addr  = 16'($urandom); d_wdata = 16'($urandom);
    tick();
    check_eq("rst_ctl", 32'({if_done, if_stall, d_done, d_stall, mem_enable, mem_wr}), 32'h0);
    check_eq("rst_rdata", 32'({if_rdata, d_rdata}), 32'h0);
    check_eq("rst_mem", 32'({mem_addr, mem_data_in}), 32'h0);
    if_req = 1'b1; d_req = 1'b1;
    tick();
    check_eq("rst_ctl2", 32'({if_done, if_stall, d_done, d_stall, mem_enable, mem_wr}), 32'h0);
    if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_en", 32'(mem_enable), 32'h0);
    end

    // 2. Lone fetch.
    if_addr = 16'h0010; if_req = 1'b1;
    #1;
    check_eq("f_stall_c0", 32'(if_stall), 32'h1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      check_eq("f_busy_pins", 32'({mem_enable, mem_wr, if_stall}), 32'h5);
      check_eq("f_busy_addr", 32'(mem_addr), 32'h0010);
      tick();
    end
    check_eq("f_done", 32'({if_done, d_done, if_stall, mem_enable}), 32'h8);
    check_eq("f_rdata", 32'(if_rdata), 32'hA5A5);
    if_req = 1'b0;
    tick();

    // 3. Store to 0x0200, then load it back.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    #1;
    check_eq("st_c0", 32'({mem_enable, mem_wr, d_stall}), 32'h1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      check_eq("st_busy_pins", 32'({mem_enable, mem_wr}), 32'h3);
      check_eq("st_busy_data", 32'({mem_addr, mem_data_in}), 32'h0200_1234);
      tick();
    end
    check_eq("st_done", 32'({d_done, if_done, mem_enable, mem_wr}), 32'h8);
    check_eq("st_rdata_kept", 32'(d_rdata), 32'h0);
    d_wr = 1'b0;
    tick();
    wait_done(n);
    check_eq("ld_lat", 32'(n), 32'd5);
    check_eq("ld_done", 32'({d_done, if_done}), 32'h2);
    check_eq("ld_rdata", 32'(d_rdata), 32'h1234);
    check_eq("ld_if_rdata", 32'(if_rdata), 32'hA5A5);
    d_req = 1'b0;
    tick();

    // 4. Simultaneous requests: data first, fetch right after.
    if_addr = 16'h0010; if_req = 1'b1;
    d_addr = 16'h0300; d_wr = 1'b0; d_req = 1'b1;
    wait_done(n);
    check_eq("tie_d_lat", 32'(n), 32'd5);
    check_eq("tie_d_done", 32'({d_done, if_done}), 32'h2);
    check_eq("tie_d_rdata", 32'(d_rdata), 32'h5900);
    d_req = 1'b0;
    tick();
    check_eq("tie_c6_idle", 32'({mem_enable, if_stall}), 32'h1);
    tick();
    check_eq("tie_c7_busy", 32'({mem_enable, mem_addr}), 32'h1_0010);
    wait_done(n);
    check_eq("tie_if_lat", 32'(n), 32'd4);
    check_eq("tie_if_done", 32'({if_done, d_done}), 32'h2);
    if_req = 1'b0;
    tick();

    // 5. Starvation: expected grant order D,D,D,IF,D,D,D,IF.
    if_addr = 16'h0010; if_req = 1'b1;
    exp_addr = 16'h0100; d_addr = exp_addr; d_wr = 1'b0; d_req = 1'b1;
    for (int t = 0; t < 8; t++) begin
      wait_done(n);
      check_eq("stv_lat", 32'(n), 32'd5);
      own = d_done ? 1 : 0;
      check_eq("stv_owner", 32'(own), (t % 4 == 3) ? 32'd0 : 32'd1);
      if (if_done) begin
        check_eq("stv_cnt_clr", 32'(dut.starve_q), 32'h0);
        check_eq("stv_if_rdata", 32'(if_rdata), 32'hA5A5);
      end else if (d_done) begin
        check_eq("stv_d_rdata", 32'(d_rdata), 32'(exp_addr ^ 16'h5A00));
        exp_addr = exp_addr + 16'h1;
        d_addr = exp_addr;
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // 6. Reset in the middle of a fetch.
    if_addr = 16'h0010; if_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_en", 32'({mem_enable, mem_wr, if_done, if_stall}), 32'h0);
    check_eq("mid_rst_rdata", 32'(if_rdata), 32'h0);
    tick();
    check_eq("mid_rst_hold", 32'({mem_enable, if_done}), 32'h0);
    rst = 1'b0;
    #1;
    wait_done(n);
    check_eq("post_rst_lat", 32'(n), 32'd5);
    check_eq("post_rst_done", 32'({if_done, d_done}), 32'h2);
    check_eq("post_rst_rdata", 32'(if_rdata), 32'hA5A5);
    if_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares a single-ported, multi-cycle memory1c instance between two requesters: the instruction-fetch path (PC side) and the data path (LW/SW effective address from the ALU).
Runs each access as a fixed-latency transaction and drives the memory's enable, wr, addr and data_in pins.
Produces per-requester stall signals, used to freeze pc_reg and the register-file writeback while an access is outstanding.
Data side wins ties; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 4, cycles the memory needs enable/addr held before data_out is valid (>=1)
STARVE_MAX, 3, max consecutive data grants issued while if_req is pending before fetch is forced

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level; held until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction
if_done  out  1  one-cycle completion pulse
if_stall  out  1  fetch outstanding; freeze PC
d_req  in  1  data request, level; held until d_done
d_wr  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  effective address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data
d_done  out  1  one-cycle completion pulse
d_stall  out  1  data access outstanding
mem_enable  out  1  to memory1c enable
mem_wr  out  1  to memory1c wr
mem_addr  out  ADDR_W  to memory1c addr
mem_data_in  out  DATA_W  to memory1c data_in
mem_data_out  in  DATA_W  from memory1c data_out

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (async, any state):
  - Go to IDLE; all outputs 0; latched addr/wdata/wr/owner, rdata registers, latency counter and starve counter cleared.
  - An in-flight transaction is discarded with no done pulse.
- IDLE:
  - Samples if_req/d_req.
  - None set: stay.
  - Otherwise grant one requester, latch its addr, wdata and wr (wr forced 0 for fetch), load counter = MEM_LAT-1, go to BUSY.
- Arbitration:
  - Only d_req: data. Only if_req: fetch.
  - Both set: data, unless starve counter == STARVE_MAX, then fetch.
  - Starve counter increments on a data grant while if_req=1 (saturates at STARVE_MAX).
  - It clears on any fetch grant, and on a data grant with if_req=0.
- BUSY:
  - Lasts exactly MEM_LAT cycles.
  - mem_enable=1; mem_addr, mem_data_in and mem_wr come from latched values (registered, stable the whole phase).
  - Counter decrements each cycle. At counter==0:
    - Reads capture mem_data_out into the owner's rdata register.
    - Go to DONE.
  - Requester inputs are ignored during BUSY; dropping req does not abort.
- DONE:
  - One cycle. mem_enable=0, mem_wr=0.
  - Owner's done=1; requests are not sampled.
  - Then go to IDLE.
- Latency: req sampled in IDLE at cycle 0 gives BUSY in cycles 1..MEM_LAT and done in cycle MEM_LAT+1. Minimum spacing between transactions is MEM_LAT+2 cycles.
- Handshake:
  - A requester seeing done deasserts req at the next edge, or keeps it high with new addr to issue another access.
  - A held req is re-arbitrated in IDLE.
- rdata registers hold their value until the next read completion for the same owner. Stores do not modify d_rdata but still pulse d_done.
- Stalls (combinational from registered state): if_stall = if_req & ~if_done; d_stall = d_req & ~d_done.
- mem_wr is never 1 when mem_enable is 0.

Decomposition:
- Shared package cpu_pkg:
  - State encoding (IDLE/BUSY/DONE, 2 bits).
  - Owner encoding (OWN_IF=0, OWN_D=1).
  - Default MEM_LAT and STARVE_MAX constants.
- Counter width is clog2(MEM_LAT), minimum 1.
- One sub-module is natural: mem_lat_counter, a loadable down-counter with a zero flag and async active-high reset.
- Arbitration and the starve counter stay inline.

Test Plan:
All scenarios use MEM_LAT=4 and STARVE_MAX=3.
1. Reset: rst=1 for 2 cycles with random inputs -> all outputs 0. After release with no requests -> mem_enable stays 0.
2. Lone fetch: if_req=1, if_addr=0x0010, mem[0x0010]=0xA5A5 at cycle 0 -> mem_enable=1, mem_addr=0x0010, mem_wr=0 in cycles 1-4; if_done=1 in cycle 5 with if_rdata=0xA5A5; if_stall=1 in cycles 0-4 and 0 in cycle 5.
3. Store then load: d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_wr=1 only in cycles 1-4, d_done in cycle 5. Then a load from 0x0200 -> d_rdata=0x1234 at its d_done; if_rdata unchanged.
4. Tie: if_req and d_req both rise at cycle 0 -> data granted, d_done in cycle 5. Fetch is granted in cycle 6, BUSY 7-10, if_done in cycle 11.
5. Starvation: d_req held continuously with new addresses and if_req held -> grant order D,D,D,IF,D,D,D,IF. The starve counter reads 0 after each fetch grant.
6. Reset mid-BUSY: rst pulses at cycle 2 of a fetch -> mem_enable=0 immediately and no if_done. After release with if_req still high -> a fresh transaction starts and if_done arrives 5 cycles after the first IDLE sample.
